// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock sequencer with timeout, bounded retries and lock qualification
module pll_lock_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRIES    = 7,
   parameter int LOSS_W         = 8,
   localparam int RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              restart,
   input  logic              pll_locked,
   output logic              pll_rst,
   output logic              sys_rst,
   output logic              ready,
   output logic              fail,
   output logic [RC_W-1:0]   retry_count,
   output logic [LOSS_W-1:0] lock_loss_count
);

   localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABILIZE,
      S_RUN,
      S_FAIL
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [RC_W-1:0]     retry_q, retry_d;
   logic [LOSS_W-1:0]   loss_q, loss_d;
   logic [1:0]          sync_q;
   logic                locked_s;

   // pll_locked is asynchronous; only the second flop is ever observed
   assign locked_s = sync_q[1];

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q <= S_RESET_PLL;
         cnt_q   <= '0;
         retry_q <= '0;
         loss_q  <= '0;
         sync_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
         sync_q  <= {sync_q[0], pll_locked};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      loss_d  = loss_q;
      if (restart) begin
         state_d = S_RESET_PLL;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         unique case (state_q)
            S_RESET_PLL: begin
               if (cnt_q == RST_LAST) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               // Lock is checked first so it wins over a same-cycle timeout
               if (locked_s) begin
                  state_d = S_STABILIZE;
                  cnt_d   = '0;
               end else if (cnt_q == TMO_LAST) begin
                  cnt_d = '0;
                  if (retry_q == RC_LAST) begin
                     state_d = S_FAIL;
                  end else begin
                     state_d = S_RESET_PLL;
                     retry_d = retry_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_STABILIZE: begin
               if (!locked_s) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
               end else if (cnt_q == STB_LAST) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  retry_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               if (!locked_s) begin
                  state_d = S_RESET_PLL;
                  cnt_d   = '0;
                  if (!(&loss_q)) begin
                     loss_d = loss_q + 1'b1;
                  end
               end
            end
            S_FAIL: begin
               state_d = S_FAIL;
            end
            default: begin
               state_d = S_RESET_PLL;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign pll_rst         = (state_q == S_RESET_PLL) || (state_q == S_FAIL);
   assign sys_rst         = (state_q != S_RUN);
   assign ready           = (state_q == S_RUN);
   assign fail            = (state_q == S_FAIL);
   assign retry_count     = retry_q;
   assign lock_loss_count = loss_q;

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the board PLL (50 MHz reference to 100 MHz core clock) from power-up through lock. It holds the PLL in reset for a fixed interval, then waits for lock with a timeout and bounded retries. Lock must be stable for a qualification window before the processor's system reset is released. The block runs on the free-running reference clock, drives the PLL `rst` input, and supervises lock loss during operation.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 50000: max cycles waiting for lock per attempt (≥1).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before release (≥1).
- `MAX_RETRIES`, 7: extra attempts after the first before declaring failure (≥0).
- `LOSS_W`, 8: width of the lock-loss counter.

Ports:
- `refclk`, in, 1: sole clock, 50 MHz reference, free-running.
- `rst`, in, 1: synchronous, active-high reset.
- `restart`, in, 1: single-cycle request to restart the sequence.
- `pll_locked`, in, 1: PLL `locked`, asynchronous to `refclk`.
- `pll_rst`, out, 1: drives PLL `rst`.
- `sys_rst`, out, 1: active-high reset to the core clock domain consumers.
- `ready`, out, 1: PLL locked and qualified.
- `fail`, out, 1: retries exhausted, sticky.
- `retry_count`, out, $clog2(MAX_RETRIES+1) (min 1): attempts used in the current sequence.
- `lock_loss_count`, out, LOSS_W: saturating count of lock losses while in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`locked_s`). Both flops reset to 0. No logic reads `pll_locked` directly.
- States: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAIL. Outputs are Moore-decoded from registered state:
  - `pll_rst` = 1 in RESET_PLL and FAIL.
  - `sys_rst` = 1 in every state except RUN.
  - `ready` = 1 only in RUN.
  - `fail` = 1 only in FAIL.
- RESET_PLL: the cycle counter runs 0..PLL_RST_CYCLES-1. At the last count the state goes to WAIT_LOCK and the counter clears.
- WAIT_LOCK: if `locked_s`=1, go to STABILIZE and clear the counter.
  - Otherwise, at counter = LOCK_TIMEOUT-1: if `retry_count` = MAX_RETRIES, go to FAIL; else increment `retry_count` and go to RESET_PLL.
  - If lock and timeout occur in the same cycle, lock wins.
- STABILIZE: if `locked_s`=0, return to WAIT_LOCK with the counter cleared. Lock loss here does not consume a retry and does not reset the timeout budget semantics beyond the counter clear.
  - At counter = STABLE_CYCLES-1 with `locked_s`=1, go to RUN.
- RUN: on entry, `retry_count` clears to 0. If `locked_s`=0, increment `lock_loss_count` (saturates at all-ones) and go to RESET_PLL.
- FAIL: absorbing. It is left only by `rst` or `restart`.
- `restart`=1 in any state: go to RESET_PLL, clear the counter, clear `retry_count`. `lock_loss_count` is unchanged. `restart` has priority over every other transition.
- `rst` has priority over everything, including `restart`.

## Timing
- Reset values, in effect the cycle after `rst` is sampled high:
  - state = RESET_PLL, counter = 0, `retry_count` = 0, `lock_loss_count` = 0, sync flops = 0.
  - `pll_rst` = 1, `sys_rst` = 1, `ready` = 0, `fail` = 0.
- `rst` held high keeps the reset values indefinitely. A mid-sequence `rst` aborts immediately, with no partial state retained.
- After `rst` falls, `pll_rst` stays high for exactly PLL_RST_CYCLES cycles.
- Startup with `pll_locked` already stable high: `ready` rises PLL_RST_CYCLES + 1 + STABLE_CYCLES cycles after the first cycle with `rst` low.
  - WAIT_LOCK lasts 1 cycle.
- Lock acquired later: `ready` rises 2 (sync) + 1 + STABLE_CYCLES cycles after `pll_locked` rises.
- Lock loss in RUN: `ready` falls and `sys_rst`/`pll_rst` rise 3 cycles after `pll_locked` falls. `lock_loss_count` updates on the same edge.
- Each failed attempt costs PLL_RST_CYCLES + LOCK_TIMEOUT cycles. `fail` rises after (MAX_RETRIES+1) attempts.
- `retry_count` increments on the WAIT_LOCK→RESET_PLL edge.
- Glitches on `pll_locked` shorter than one `refclk` period may be missed. This is acceptable.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, LOSS_W=8.

1. `pll_locked`=1 constantly, release `rst` → `pll_rst` high 4 cycles, `ready`=1 and `sys_rst`=0 exactly 13 cycles after `rst` low, `retry_count`=0.
2. `pll_locked`=0 forever → `retry_count` steps 1, 2, then `fail`=1 after 72 cycles, with `pll_rst`=1 and `sys_rst`=1. `restart` pulse → RESET_PLL, `fail`=0, `retry_count`=0.
3. In RUN, drop `pll_locked` → `ready`=0 3 cycles later, `lock_loss_count`=1. Re-raise `pll_locked` → `ready` returns after 4 + 1 + 8 cycles. Force 300 losses → counter saturates at 255.
4. `pll_locked` drops for 3 cycles at STABILIZE count 5 → back to WAIT_LOCK, no retry consumed. `ready` only after 8 uninterrupted locked cycles.
5. `pll_locked` rises so that `locked_s`=1 on the exact WAIT_LOCK timeout cycle (count 19) → STABILIZE entered, `retry_count` unchanged.
6. Assert `rst` during STABILIZE and during RUN, and assert `rst` together with `restart` → all outputs at reset values next cycle, sequence restarts from a full 4-cycle `pll_rst`.
